ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte, such as LED set 0xED or reset 0xFF, to a PS/2 keyboard. It runs the request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge. It shares the bidirectional `ps2_clk`/`ps2_data` pins with the existing PS/2 keyboard receiver through open-drain enables at the top level. `tx_busy` gates that receiver so it ignores the host frame.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, device-clocked shift-out of
// data/parity/stop, and acknowledge check. Pins are driven open-drain via the *_oe outputs.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES    = 5000,
   parameter int unsigned SETUP_CYCLES      = 50,
   parameter int unsigned FIRST_CLK_TIMEOUT = 750000,
   parameter int unsigned BIT_TIMEOUT       = 100000,
   parameter int unsigned FILTER_CYCLES     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [1:0] tx_err
);

   localparam int unsigned FW = $clog2(FILTER_CYCLES) + 1;

   localparam logic [19:0] LimInhibit = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] LimSetup   = 20'(SETUP_CYCLES - 1);
   localparam logic [19:0] LimFirst   = 20'(FIRST_CLK_TIMEOUT - 1);
   localparam logic [19:0] LimBit     = 20'(BIT_TIMEOUT - 1);

   typedef enum logic [3:0] {
      StIdle, StInhibit, StStart, StWaitFirst, StShift, StAck, StWaitIdle, StDone, StErr
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  clk_s, data_s;
   logic        filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic        fall_q, fall_d;
   logic [19:0] tcnt_q, tcnt_d;
   logic [19:0] lim;
   logic        tmo;
   logic [7:0]  sr_q, sr_d;
   logic        par_q, par_d;
   logic [3:0]  bit_q, bit_d;
   logic [1:0]  err_q, err_d;
   logic        clk_sync, data_sync;

   assign clk_sync  = clk_s[1];
   assign data_sync = data_s[1];

   // Synchronizers idle high so reset never manufactures a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s  <= 2'b11;
         data_s <= 2'b11;
         filt_q <= 1'b1;
         fcnt_q <= '0;
         fall_q <= 1'b0;
      end else begin
         clk_s  <= {clk_s[0], ps2_clk_in};
         data_s <= {data_s[0], ps2_data_in};
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
         fall_q <= fall_d;
      end
   end

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_sync != filt_q) begin
         if (fcnt_q == FW'(FILTER_CYCLES - 1)) filt_d = clk_sync;
         else                                  fcnt_d = fcnt_q + 1'b1;
      end
      fall_d = filt_q & ~filt_d;
   end

   always_comb begin
      lim = LimBit;
      unique case (state_q)
         StInhibit:   lim = LimInhibit;
         StStart:     lim = LimSetup;
         StWaitFirst: lim = LimFirst;
         default:     lim = LimBit;
      endcase
   end

   assign tmo = (tcnt_q == lim);

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      par_d       = par_q;
      bit_d       = bit_q;
      err_d       = err_q;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      tx_busy     = 1'b1;
      tx_done     = 1'b0;
      tx_err      = 2'b00;
      unique case (state_q)
         StIdle: begin
            tx_busy = 1'b0;
            if (tx_start) begin
               sr_d    = tx_data;
               par_d   = ~^tx_data;
               state_d = StInhibit;
            end
         end
         StInhibit: begin
            ps2_clk_oe = 1'b1;
            if (tmo) state_d = StStart;
         end
         StStart: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            if (tmo) state_d = StWaitFirst;
         end
         StWaitFirst: begin
            ps2_data_oe = 1'b1;
            if (fall_q) begin
               bit_d   = 4'd1;
               state_d = StShift;
            end else if (tmo) begin
               err_d   = 2'b01;
               state_d = StErr;
            end
         end
         StShift: begin
            // bit_q counts bits driven so far; 1..8 are data (LSB in sr_q[0]), 9 is parity.
            ps2_data_oe = (bit_q == 4'd9) ? ~par_q : ~sr_q[0];
            if (fall_q) begin
               if (bit_q == 4'd9) begin
                  state_d = StAck;
               end else begin
                  if (bit_q < 4'd8) sr_d = {1'b0, sr_q[7:1]};
                  bit_d = bit_q + 4'd1;
               end
            end else if (tmo) begin
               err_d   = 2'b10;
               state_d = StErr;
            end
         end
         StAck: begin
            if (fall_q) begin
               if (!data_sync) begin
                  state_d = StWaitIdle;
               end else begin
                  err_d   = 2'b11;
                  state_d = StErr;
               end
            end else if (tmo) begin
               err_d   = 2'b10;
               state_d = StErr;
            end
         end
         StWaitIdle: begin
            if (filt_q && data_sync) begin
               state_d = StDone;
            end else if (tmo) begin
               err_d   = 2'b10;
               state_d = StErr;
            end
         end
         StDone: begin
            tx_done = 1'b1;
            state_d = StIdle;
         end
         StErr: begin
            tx_done = 1'b1;
            tx_err  = err_q;
            state_d = StIdle;
         end
         default: begin
            tx_busy = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // Timeout restarts on every state entry and on each accepted device edge.
   always_comb begin
      if ((state_d != state_q) ||
          (fall_q && (state_q inside {StWaitFirst, StShift, StAck}))) begin
         tcnt_d = '0;
      end else begin
         tcnt_d = tcnt_q + 20'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         tcnt_q  <= '0;
         sr_q    <= '0;
         par_q   <= 1'b0;
         bit_q   <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the wired-AND pins, a scoreboard queue holds
// expected results and a monitor checks each tx_done against them.
module tb_ps2_host_tx;

   localparam int INH   = 50;
   localparam int SETUP = 10;
   localparam int FIRST = 3000;
   localparam int BITT  = 1000;
   localparam int FILT  = 4;
   localparam int HALF  = 60;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done;
   logic [1:0] tx_err;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES   (INH),
      .SETUP_CYCLES     (SETUP),
      .FIRST_CLK_TIMEOUT(FIRST),
      .BIT_TIMEOUT      (BITT),
      .FILTER_CYCLES    (FILT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_err     (tx_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  err;
      logic [10:0] frame;
      bit          chk_bits;
      int          mode;   // 0: none, 1: first-clock timeout timing, 2: bit timeout timing
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_fall_cyc = 0;
   logic [10:0] dev_bits = '0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame as the device sees it: start, data LSB first, odd parity, stop.
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0), d, 1'b0};
   endfunction

   task automatic device_frame(input int nedges, input bit ack);
      int w = 0;
      while (!(!ps2_clk_oe && ps2_data_oe) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("dev_rts_seen", 32'(w < 2000), 1);
      dev_bits[0] = ps2_data_in;
      repeat (HALF) @(negedge clk);
      for (int e = 1; e <= nedges; e++) begin
         if (e == 11 && ack) dev_data = 1'b0;
         repeat (4) @(negedge clk);
         dev_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         if (e <= 10) dev_bits[e] = ps2_data_in;
         repeat (HALF) @(negedge clk);
         dev_data = 1'b1;
      end
   endtask

   task automatic wait_idle(input int limit);
      int w = 0;
      while (tx_busy && w < limit) begin
         @(negedge clk);
         w++;
      end
      if (tx_busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_end: tx_busy still 1 after %0d cycles, required 0", limit);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input int nedges, input bit ack,
                       input logic [1:0] err, input int mode, input bit dup);
      exp_t e;
      e.err      = err;
      e.frame    = ref_frame(d);
      e.chk_bits = (nedges == 11);
      e.mode     = mode;
      q.push_back(e);
      dev_bits = '0;
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = ~d;
      if (dup) begin
         repeat (5) @(negedge clk);
         tx_start = 1'b1;
         @(negedge clk);
         tx_start = 1'b0;
      end
      if (nedges > 0) device_frame(nedges, ack);
      wait_idle(20000);
   endtask

   // Monitor: tracks oe timing and checks every tx_done against the scoreboard.
   initial begin
      bit   pc = 1'b0;
      bit   pd = 1'b0;
      int   run = 0, last_run = 0, rise = 0, drise = 0, cfall = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (ps2_clk_oe) begin
            if (!pc) begin
               rise = cyc;
               run  = 0;
            end
            run++;
         end else if (pc) begin
            last_run = run;
            cfall    = cyc;
         end
         if (ps2_data_oe && !pd && ps2_clk_oe) drise = cyc;
         pc = ps2_clk_oe;
         pd = ps2_data_oe;
         if (tx_done) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: tx_done=1 err=%0d, required no done", tx_err);
            end else begin
               e = q.pop_front();
               chk("tx_err", 32'(tx_err), 32'(e.err));
               chk("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
               chk("clk_oe_len", last_run, INH + SETUP);
               chk("data_oe_delay", drise - rise, INH);
               if (e.chk_bits) chk("frame_bits", 32'(dev_bits), 32'(e.frame));
               if (e.mode == 1) chk("first_tmo_cycles", cyc - cfall, FIRST);
               if (e.mode == 2) chk("bit_tmo_cycles", cyc - last_fall_cyc, 3 + FILT + BITT);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      chk("rst_busy_done", {30'd0, tx_busy, tx_done}, 0);
      chk("rst_err", 32'(tx_err), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      send(8'hED, 11, 1'b1, 2'b00, 0, 1'b0);
      send(8'h01, 11, 1'b1, 2'b00, 0, 1'b0);
      send(8'h00, 11, 1'b1, 2'b00, 0, 1'b0);
      send(8'hFF, 11, 1'b1, 2'b00, 0, 1'b1);
      for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 11, 1'b1, 2'b00, 0, 1'b0);
      send(8'h3C, 0, 1'b0, 2'b01, 1, 1'b0);
      send(8'hA7, 4, 1'b0, 2'b10, 2, 1'b0);
      send(8'h96, 11, 1'b0, 2'b11, 0, 1'b0);

      // Reset in the middle of SHIFT, with bit 2 (a zero) on the line.
      @(negedge clk);
      tx_data  = 8'h5A;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      device_frame(3, 1'b0);
      chk("pre_rst_busy", 32'(tx_busy), 1);
      chk("pre_rst_data_oe", 32'(ps2_data_oe), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      chk("mid_rst_busy_done", {30'd0, tx_busy, tx_done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      send(8'hC3, 11, 1'b1, 2'b00, 0, 1'b0);
      send(8'($urandom_range(0, 255)), 11, 1'b1, 2'b00, 0, 1'b0);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
